// File: rtl/pipe_hazard_exc_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and its hazard/exception
// controller.
//   master : pipeline side. It drives the ID/EX status, irq and mem_busy, and it
//            receives the enables, flushes, strobes, vector and return address.
//   slave  : controller side (pipe_hazard_exc_ctrl).
// There is no valid/ready handshake here. EX_valid marks a real instruction in
// EX, and the controller answers in the same cycle through pc_write/ifid_write
// (hold) and ifid_flush/idex_flush (bubble). A strobe or flush is only meaningful
// in the cycle it is high, and the datapath must register it at the next clk edge.
interface pipe_hazard_exc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_uses_rt;
  logic             ID_jump;
  logic             EX_valid;
  logic             EX_MemRead;
  logic [4:0]       EX_rt;
  logic             EX_branch_taken;
  logic             EX_illop;
  logic [31:0]      EX_PC;
  logic             irq;
  logic             mem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_illop;
  logic             exmem_xadr;
  logic [31:0]      exc_ret;
  logic             pc_vec_sel;
  logic [31:0]      exc_vec;
  logic [CNT_W-1:0] exc_count;
  logic [1:0]       state;

  modport master (
    output ID_rs, ID_rt, ID_uses_rt, ID_jump, EX_valid, EX_MemRead, EX_rt,
           EX_branch_taken, EX_illop, EX_PC, irq, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_illop,
           exmem_xadr, exc_ret, pc_vec_sel, exc_vec, exc_count, state
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rt, ID_jump, EX_valid, EX_MemRead, EX_rt,
           EX_branch_taken, EX_illop, EX_PC, irq, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_illop,
           exmem_xadr, exc_ret, pc_vec_sel, exc_vec, exc_count, state
  );
endinterface

// File: rtl/pipe_hazard_exc_ctrl.sv
// Central sequencing controller for the 5-stage pipeline.
// It handles load-use, branch and jump hazards, and it takes illegal-opcode and
// external-interrupt exceptions. While data memory is busy it stalls the whole pipe.
// Ports:
//   clk, reset : clock and asynchronous active-high reset.
//   bus        : pipe_hazard_exc_ctrl_if.slave. ID/EX status, irq and mem_busy
//                come in. PC/IF-ID enables, flushes, illop/xadr strobes,
//                exc_ret/exc_vec/pc_vec_sel, the saturating exc_count and the
//                debug state (0 RUN, 1 DRAIN, 2 ENTER) go out.
// Per-cycle priority: mem_busy > exception > branch > load-use > jump.
module pipe_hazard_exc_ctrl #(
  parameter logic [31:0] ILLOP_VEC = 32'h80000004,
  parameter logic [31:0] IRQ_VEC   = 32'h80000008,
  parameter int          CNT_W     = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_hazard_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_ENTER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             irq_d_q;
  logic             irq_pend_q;
  // Exception latched while memory is busy. It is replayed when DRAIN exits.
  logic             cause_illop_q;
  logic             cause_irq_q;
  logic [31:0]      ret_q;
  // An illop seen during ENTER is parked here and taken in the following RUN cycle.
  logic             held_q;
  logic [31:0]      held_ret_q;
  logic [CNT_W-1:0] count_q;

  logic        ex_illop;
  logic        irq_ok;
  logic        irq_rise;
  logic        load_use;
  logic        run_illop;
  logic        run_irq;
  logic [31:0] run_ret;

  logic        take;
  logic        take_illop;
  logic        take_irq;
  logic [31:0] take_ret;
  logic        latch;
  logic        hold_set;
  logic        hazard_en;
  logic        stall;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_illop;
  logic        exmem_xadr;
  logic        pc_vec_sel;
  logic [31:0] exc_vec;
  logic [31:0] exc_ret;

  assign ex_illop = bus.EX_valid & bus.EX_illop;
  // An interrupt may only land on a real user-mode instruction that is not itself illegal.
  assign irq_ok   = irq_pend_q & bus.EX_valid & ~bus.EX_PC[31] & ~bus.EX_illop;
  assign irq_rise = bus.irq & ~irq_d_q;
  assign load_use = bus.EX_MemRead & (bus.EX_rt != 5'd0) &
                    ((bus.EX_rt == bus.ID_rs) |
                     (bus.ID_uses_rt & (bus.EX_rt == bus.ID_rt)));

  // A parked illop outranks whatever is in EX now. An illop always beats an irq.
  assign run_illop = held_q | ex_illop;
  assign run_irq   = ~run_illop & irq_ok;
  // An interrupted instruction is re-executed, so its own PC is the return address.
  assign run_ret   = held_q   ? held_ret_q :
                     ex_illop ? bus.EX_PC + 32'd4 : bus.EX_PC;

  // Next-state and action selection.
  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    take_illop = 1'b0;
    take_irq   = 1'b0;
    take_ret   = 32'h0;
    latch      = 1'b0;
    hold_set   = 1'b0;
    hazard_en  = 1'b0;
    stall      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (run_illop | run_irq) begin
          if (bus.mem_busy) begin
            stall   = 1'b1;
            latch   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            take       = 1'b1;
            take_illop = run_illop;
            take_irq   = run_irq;
            take_ret   = run_ret;
            state_d    = S_ENTER;
          end
        end else if (bus.mem_busy) begin
          stall = 1'b1;
        end else begin
          hazard_en = 1'b1;
        end
      end
      S_DRAIN: begin
        // EX inputs are ignored here. Only the latched exception can fire.
        if (bus.mem_busy) begin
          stall = 1'b1;
        end else begin
          take       = 1'b1;
          take_illop = cause_illop_q;
          take_irq   = cause_irq_q;
          take_ret   = ret_q;
          state_d    = S_ENTER;
        end
      end
      S_ENTER: begin
        state_d = S_RUN;
        // If the pipe is stalled, the illop stays in EX and is seen again in RUN.
        hold_set = ex_illop & ~bus.mem_busy;
        if (bus.mem_busy) stall = 1'b1;
        else              hazard_en = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output decode.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_illop = 1'b0;
    exmem_xadr  = 1'b0;
    pc_vec_sel  = 1'b0;
    exc_vec     = 32'h0;
    exc_ret     = 32'h0;
    if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (take) begin
      exmem_illop = take_illop;
      exmem_xadr  = take_irq;
      pc_vec_sel  = 1'b1;
      exc_vec     = take_illop ? ILLOP_VEC : IRQ_VEC;
      exc_ret     = take_ret;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (hazard_en) begin
      if (bus.EX_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // The stall also covers a jump in ID. The jump is retried next cycle.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end else if (bus.ID_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      irq_d_q       <= 1'b0;
      irq_pend_q    <= 1'b0;
      cause_illop_q <= 1'b0;
      cause_irq_q   <= 1'b0;
      ret_q         <= 32'h0;
      held_q        <= 1'b0;
      held_ret_q    <= 32'h0;
      count_q       <= '0;
    end else begin
      state_q <= state_d;
      irq_d_q <= bus.irq;
      // A new edge in the same cycle as the xadr strobe keeps the interrupt pending.
      if (irq_rise)        irq_pend_q <= 1'b1;
      else if (exmem_xadr) irq_pend_q <= 1'b0;

      if (latch) begin
        cause_illop_q <= run_illop;
        cause_irq_q   <= run_irq;
        ret_q         <= run_ret;
      end else if (take && (state_q == S_DRAIN)) begin
        cause_illop_q <= 1'b0;
        cause_irq_q   <= 1'b0;
      end

      if (hold_set) begin
        held_q     <= 1'b1;
        held_ret_q <= bus.EX_PC + 32'd4;
      end else if ((state_q == S_RUN) && (take || latch)) begin
        held_q <= 1'b0;
      end

      if (take && (count_q != '1)) count_q <= count_q + CNT_ONE;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_illop = exmem_illop;
  assign bus.exmem_xadr  = exmem_xadr;
  assign bus.pc_vec_sel  = pc_vec_sel;
  assign bus.exc_vec     = exc_vec;
  assign bus.exc_ret     = exc_ret;
  assign bus.exc_count   = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_hazard_exc_ctrl.sv
// Testbench for pipe_hazard_exc_ctrl.
// A table of single-cycle hazard vectors runs first, then hand-written sequences
// for exceptions, DRAIN, ENTER hold-off and reset during DRAIN.
// Every exception taken must match an entry in exp_q.
module tb_pipe_hazard_exc_ctrl;
  localparam int CNT_W = 2;  // narrow so saturation is reachable
  localparam logic [31:0] ILLOP_VEC = 32'h80000004;
  localparam logic [31:0] IRQ_VEC   = 32'h80000008;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_exc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_exc_ctrl #(
    .ILLOP_VEC(ILLOP_VEC),
    .IRQ_VEC(IRQ_VEC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       memread;
    logic [4:0] ex_rt;
    logic       br;
    logic       busy;
    logic [3:0] exp;  // {pc_write, ifid_write, ifid_flush, idex_flush}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string n, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt, input logic jump,
                         input logic memread, input logic [4:0] ex_rt, input logic br,
                         input logic busy, input logic [3:0] exp);
    vecs[i].name = n;       vecs[i].rs = rs;       vecs[i].rt = rt;
    vecs[i].uses_rt = uses_rt; vecs[i].jump = jump; vecs[i].memread = memread;
    vecs[i].ex_rt = ex_rt;  vecs[i].br = br;       vecs[i].busy = busy;
    vecs[i].exp = exp;
  endtask

  task automatic clear_in();
    bus.ID_rs = '0; bus.ID_rt = '0; bus.ID_uses_rt = 1'b0; bus.ID_jump = 1'b0;
    bus.EX_valid = 1'b0; bus.EX_MemRead = 1'b0; bus.EX_rt = '0;
    bus.EX_branch_taken = 1'b0; bus.EX_illop = 1'b0; bus.EX_PC = '0;
    bus.irq = 1'b0; bus.mem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_ex(input logic illop, input logic [31:0] pc, input logic busy);
    clear_in();
    bus.EX_valid = 1'b1;
    bus.EX_illop = illop;
    bus.EX_PC    = pc;
    bus.mem_busy = busy;
  endtask

  // Each exception taken is checked against the next expected return address.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.pc_vec_sel === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exception: got exc_ret %h expected no exception", bus.exc_ret);
      end else begin
        chk("exc_ret", bus.exc_ret, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_in();
    set_vec(0,  "idle",            5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 4'b1100);
    set_vec(1,  "loaduse_rs",      5'd8, 5'd0, 0, 0, 1, 5'd8, 0, 0, 4'b0001);
    set_vec(2,  "loaduse_rt0",     5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 4'b1100);
    set_vec(3,  "loaduse_rt",      5'd3, 5'd5, 1, 0, 1, 5'd5, 0, 0, 4'b0001);
    set_vec(4,  "rt_not_used",     5'd3, 5'd5, 0, 0, 1, 5'd5, 0, 0, 4'b1100);
    set_vec(5,  "load_nomatch",    5'd8, 5'd7, 1, 0, 1, 5'd9, 0, 0, 4'b1100);
    set_vec(6,  "branch",          5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 4'b1111);
    set_vec(7,  "branch_loaduse",  5'd8, 5'd0, 0, 0, 1, 5'd8, 1, 0, 4'b1111);
    set_vec(8,  "jump",            5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 4'b1110);
    set_vec(9,  "jump_loaduse",    5'd8, 5'd0, 0, 1, 1, 5'd8, 0, 0, 4'b0001);
    set_vec(10, "mem_busy",        5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 4'b0000);
    set_vec(11, "busy_branch",     5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 4'b0000);
    set_vec(12, "branch_jump",     5'd0, 5'd0, 0, 1, 0, 5'd0, 1, 0, 4'b1111);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", bus.state, 2'd0);
    chk("rst_count", bus.exc_count, 2'd0);
    chk("rst_enables", {bus.pc_write, bus.ifid_write}, 2'b11);
    chk("rst_strobes", {bus.ifid_flush, bus.idex_flush, bus.exmem_illop,
                        bus.exmem_xadr, bus.pc_vec_sel}, 5'b0);
    step();
    reset = 1'b0;

    // Hazard table
    for (int i = 0; i < 13; i++) begin
      clear_in();
      bus.ID_rs = vecs[i].rs; bus.ID_rt = vecs[i].rt;
      bus.ID_uses_rt = vecs[i].uses_rt; bus.ID_jump = vecs[i].jump;
      bus.EX_MemRead = vecs[i].memread; bus.EX_rt = vecs[i].ex_rt;
      bus.EX_branch_taken = vecs[i].br; bus.mem_busy = vecs[i].busy;
      @(negedge clk);
      chk(vecs[i].name, {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush},
          vecs[i].exp);
      chk({vecs[i].name, "_state"}, bus.state, 2'd0);
      step();
    end

    // Illegal opcode
    apply_ex(1'b1, 32'h00400010, 1'b0);
    exp_q.push_back(32'h00400014);
    @(negedge clk);
    chk("illop_strobe", {bus.exmem_illop, bus.exmem_xadr, bus.pc_vec_sel}, 3'b101);
    chk("illop_vec", bus.exc_vec, ILLOP_VEC);
    chk("illop_flush", {bus.pc_write, bus.ifid_flush, bus.idex_flush}, 3'b111);
    chk("illop_state_run", bus.state, 2'd0);
    step();
    clear_in();
    @(negedge clk);
    chk("illop_state_enter", bus.state, 2'd2);
    chk("illop_count", bus.exc_count, 2'd1);
    step();
    @(negedge clk);
    chk("illop_state_back", bus.state, 2'd0);
    step();

    // Interrupt masked in kernel mode, then taken in user mode
    apply_ex(1'b0, 32'h80000100, 1'b0);
    bus.irq = 1'b1;
    @(negedge clk);
    chk("irq_edge_nostrobe", bus.exmem_xadr, 1'b0);
    step();
    @(negedge clk);
    chk("irq_kernel_masked", {bus.exmem_xadr, bus.pc_vec_sel}, 2'b00);
    step();
    bus.EX_PC = 32'h00400020;
    exp_q.push_back(32'h00400020);
    @(negedge clk);
    chk("irq_strobe", {bus.exmem_illop, bus.exmem_xadr, bus.pc_vec_sel}, 3'b011);
    chk("irq_vec", bus.exc_vec, IRQ_VEC);
    step();
    @(negedge clk);
    chk("irq_enter_nostrobe", {bus.exmem_xadr, bus.state}, {1'b0, 2'd2});
    chk("irq_count", bus.exc_count, 2'd2);
    step();
    @(negedge clk);
    chk("irq_pend_cleared", {bus.exmem_xadr, bus.state}, {1'b0, 2'd0});
    step();
    clear_in();
    step();

    // Illegal opcode while memory is busy for three cycles
    apply_ex(1'b1, 32'h00400100, 1'b1);
    exp_q.push_back(32'h00400104);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("drain_stall", {bus.pc_write, bus.ifid_write, bus.pc_vec_sel}, 3'b000);
      chk("drain_state", bus.state, (c == 0) ? 2'd0 : 2'd1);
      step();
      apply_ex(1'b0, 32'h12345678, 1'b1);
    end
    bus.mem_busy = 1'b0;
    @(negedge clk);
    chk("drain_strobe", {bus.exmem_illop, bus.pc_vec_sel, bus.pc_write}, 3'b111);
    chk("drain_vec", bus.exc_vec, ILLOP_VEC);
    chk("drain_state_exit", bus.state, 2'd1);
    step();
    clear_in();
    @(negedge clk);
    chk("drain_enter", bus.state, 2'd2);
    chk("drain_count", bus.exc_count, 2'd3);
    step();
    step();

    // Branch and illop together: the illop wins. Count saturates.
    apply_ex(1'b1, 32'h00400200, 1'b0);
    bus.EX_branch_taken = 1'b1;
    exp_q.push_back(32'h00400204);
    @(negedge clk);
    chk("brill_strobe", bus.exmem_illop, 1'b1);
    chk("brill_vec", bus.exc_vec, ILLOP_VEC);
    step();
    // An illop during ENTER is held off one cycle
    apply_ex(1'b1, 32'h00400300, 1'b0);
    @(negedge clk);
    chk("enter_illop_held", {bus.pc_vec_sel, bus.exmem_illop, bus.state}, {2'b00, 2'd2});
    chk("count_saturated", bus.exc_count, 2'd3);
    exp_q.push_back(32'h00400304);
    step();
    clear_in();
    @(negedge clk);
    chk("held_illop_taken", {bus.exmem_illop, bus.state}, {1'b1, 2'd0});
    chk("held_illop_vec", bus.exc_vec, ILLOP_VEC);
    step();
    step();

    // Reset during DRAIN, with an irq pending
    apply_ex(1'b1, 32'h00400400, 1'b1);
    bus.irq = 1'b1;
    step();
    @(negedge clk);
    chk("rstdrain_state", bus.state, 2'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstdrain_state_async", bus.state, 2'd0);
    chk("rstdrain_count", bus.exc_count, 2'd0);
    clear_in();
    step();
    reset = 1'b0;
    bus.EX_valid = 1'b1;
    bus.EX_PC = 32'h00400500;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstdrain_nostrobe", {bus.exmem_illop, bus.exmem_xadr, bus.pc_vec_sel}, 3'b000);
      chk("rstdrain_run", bus.state, 2'd0);
      step();
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
